r22sdf_ctrl: RTL

- Sequencer for a streaming radix-2² single-delay-feedback FFT pipeline of NSTAGE = N_LOG2/2 stage pairs.
- Each stage pair is BF1, then BF2, then a twiddle multiplier.
- Counts input samples and generates, per stage pair, the BF1 butterfly select, the BF2 2-bit control (bit0 = butterfly, bit1 = 1 selects the plain path, 0 selects the −j path) and the twiddle ROM address, each aligned to that stage's pipeline offset.
- Also tracks frame state, drains the pipeline after input stops, and produces output valid/last.

---
 rtl/r22sdf_ctrl_if.sv | 41 ++++
 rtl/r22sdf_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/r22sdf_ctrl_if.sv
// Stream-side signals of the radix-2^2 SDF FFT sequencer.
// The sequencer is the slave; the sample source and pipeline datapath form the master.
interface r22sdf_ctrl_if #(
    parameter int N_LOG2 = 8
);
    localparam int NSTAGE = N_LOG2 / 2;

    logic                       sync_in;
    logic                       din_valid;
    logic [NSTAGE-1:0]          bf1_ctrl;
    logic [2*NSTAGE-1:0]        bf2_ctrl;
    logic [NSTAGE*N_LOG2-1:0]   tw_addr;
    logic                       dout_valid;
    logic                       dout_last;
    logic                       busy;
    logic                       err;

    modport master (
        output sync_in,
        output din_valid,
        input  bf1_ctrl,
        input  bf2_ctrl,
        input  tw_addr,
        input  dout_valid,
        input  dout_last,
        input  busy,
        input  err
    );

    modport slave (
        input  sync_in,
        input  din_valid,
        output bf1_ctrl,
        output bf2_ctrl,
        output tw_addr,
        output dout_valid,
        output dout_last,
        output busy,
        output err
    );
endinterface

// File: rtl/r22sdf_ctrl.sv
// Control sequencer for a radix-2^2 single-delay-feedback FFT pipeline:
// per-stage butterfly/twiddle controls, frame tracking, flush and output valid.
module r22sdf_ctrl #(
    parameter int N_LOG2    = 8,
    parameter int STAGE_LAT = 1,
    parameter int OUT_LAT   = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    r22sdf_ctrl_if.slave   bus
);
    localparam int NSTAGE = N_LOG2 / 2;
    localparam int FW     = $clog2(OUT_LAT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] CNT_LAST = '1;
    localparam logic [FW-1:0]     FL_ONE   = FW'(1);
    localparam logic [FW-1:0]     FL_END   = FW'(OUT_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [N_LOG2-1:0] cnt;
    logic [N_LOG2-1:0] cnt_nxt;
    logic [N_LOG2-1:0] cnt_cur;
    logic [FW-1:0]     fcnt;
    logic [FW-1:0]     fcnt_nxt;
    logic              err_nxt;
    logic              err_q;
    logic              accept;
    logic              cnt_nz;
    logic              vin;
    logic              lin;

    assign accept  = bus.sync_in & bus.din_valid;
    assign cnt_nz  = (cnt != '0);
    // A sample accepted with sync is count 0 whatever the counter holds.
    assign cnt_cur = accept ? '0 : cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fcnt_nxt  = fcnt;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_nxt = CNT_ONE;
                    err_nxt = cnt_nz;
                end else if (!bus.din_valid) begin
                    state_nxt = FLUSH;
                    fcnt_nxt  = '0;
                    cnt_nxt   = cnt + CNT_ONE;
                    err_nxt   = cnt_nz;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            FLUSH: begin
                cnt_nxt = cnt + CNT_ONE;
                if (accept) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_ONE;
                end else if (fcnt == FL_END) begin
                    state_nxt = IDLE;
                end else begin
                    fcnt_nxt = fcnt + FL_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            fcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            fcnt  <= fcnt_nxt;
            err_q <= err_nxt;
        end
    end

    logic [NSTAGE-1:0]        bf1_d;
    logic [NSTAGE-1:0]        bf1_q;
    logic [2*NSTAGE-1:0]      bf2_d;
    logic [2*NSTAGE-1:0]      bf2_q;
    logic [NSTAGE*N_LOG2-1:0] tw_d;
    logic [NSTAGE*N_LOG2-1:0] tw_q;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int W = N_LOG2 - 2 * k;
        localparam int M = W - 1;

        logic [W-1:0] ck;

        // Later stages see the same sample k*STAGE_LAT cycles later.
        assign ck = cnt_cur[W-1:0] - W'(k * STAGE_LAT);

        assign bf1_d[k]       = ck[M];
        assign bf2_d[2*k]     = ck[M-1];
        assign bf2_d[2*k + 1] = ~(ck[M] & ck[M-1]);

        if (W > 2) begin : g_tw
            logic [N_LOG2-1:0] scale;
            logic [N_LOG2-1:0] low;

            assign scale = {{(N_LOG2-2){1'b0}}, ck[M-1], ck[M]};
            assign low   = {{(N_LOG2-W+2){1'b0}}, ck[M-2:0]};
            assign tw_d[k*N_LOG2 +: N_LOG2] = scale * low;
        end else begin : g_tw0
            assign tw_d[k*N_LOG2 +: N_LOG2] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf1_q <= '0;
            bf2_q <= '0;
            tw_q  <= '0;
        end else if (state_nxt != IDLE) begin
            bf1_q <= bf1_d;
            bf2_q <= bf2_d;
            tw_q  <= tw_d;
        end else begin
            bf1_q <= '0;
            bf2_q <= '0;
            tw_q  <= '0;
        end
    end

    assign vin = bus.din_valid & ((state != IDLE) | bus.sync_in);
    assign lin = vin & (cnt_cur == CNT_LAST);

    logic [OUT_LAT-1:0] vsr;
    logic [OUT_LAT-1:0] lsr;

    // The delay line keeps shifting in IDLE so the pipeline tail drains.
    if (OUT_LAT == 1) begin : g_d1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vsr <= '0;
                lsr <= '0;
            end else begin
                vsr <= vin;
                lsr <= lin;
            end
        end
    end else begin : g_dn
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vsr <= '0;
                lsr <= '0;
            end else begin
                vsr <= {vsr[OUT_LAT-2:0], vin};
                lsr <= {lsr[OUT_LAT-2:0], lin};
            end
        end
    end

    assign bus.bf1_ctrl   = bf1_q;
    assign bus.bf2_ctrl   = bf2_q;
    assign bus.tw_addr    = tw_q;
    assign bus.dout_valid = vsr[OUT_LAT-1];
    assign bus.dout_last  = lsr[OUT_LAT-1];
    assign bus.busy       = (state != IDLE);
    assign bus.err        = err_q;
endmodule
